// File: rtl/id_ex_pipe_reg.sv
// Decode-to-Execute pipeline register with stall/flush control and a
// saturating bubble counter for performance monitoring.
module id_ex_pipe_reg #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              BubbleClr,
    input  logic [3:0]        CondD,
    input  logic [1:0]        FlagWriteD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              MemtoRegD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [3:0]        ALUControlD,
    input  logic [WIDTH-1:0]  RD1D,
    input  logic [WIDTH-1:0]  RD2D,
    input  logic [WIDTH-1:0]  ExtImmD,
    input  logic [3:0]        WA3D,
    input  logic [3:0]        RA1D,
    input  logic [3:0]        RA2D,
    output logic [3:0]        CondE,
    output logic [1:0]        FlagWriteE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              MemtoRegE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [3:0]        ALUControlE,
    output logic [WIDTH-1:0]  RD1E,
    output logic [WIDTH-1:0]  RD2E,
    output logic [WIDTH-1:0]  ExtImmE,
    output logic [3:0]        WA3E,
    output logic [3:0]        RA1E,
    output logic [3:0]        RA2E,
    output logic              ValidE,
    output logic [BCNT_W-1:0] BubbleCount
);

    // Condition "never": a bubble can never pass the condition check.
    localparam logic [3:0]        COND_NV  = 4'b1111;
    localparam logic [BCNT_W-1:0] BCNT_MAX = {BCNT_W{1'b1}};

    logic [3:0]        cond_q, cond_d;
    logic [1:0]        flag_write_q, flag_write_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              branch_q, branch_d;
    logic              alu_src_q, alu_src_d;
    logic [3:0]        alu_control_q, alu_control_d;
    logic [WIDTH-1:0]  rd1_q, rd1_d;
    logic [WIDTH-1:0]  rd2_q, rd2_d;
    logic [WIDTH-1:0]  ext_imm_q, ext_imm_d;
    logic [3:0]        wa3_q, wa3_d;
    logic [3:0]        ra1_q, ra1_d;
    logic [3:0]        ra2_q, ra2_d;
    logic              valid_q, valid_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    // Pipeline fields: flush beats stall beats load.
    always_comb begin
        cond_d        = cond_q;
        flag_write_d  = flag_write_q;
        reg_write_d   = reg_write_q;
        mem_write_d   = mem_write_q;
        mem_to_reg_d  = mem_to_reg_q;
        branch_d      = branch_q;
        alu_src_d     = alu_src_q;
        alu_control_d = alu_control_q;
        rd1_d         = rd1_q;
        rd2_d         = rd2_q;
        ext_imm_d     = ext_imm_q;
        wa3_d         = wa3_q;
        ra1_d         = ra1_q;
        ra2_d         = ra2_q;
        valid_d       = valid_q;
        if (FlushE) begin
            cond_d        = COND_NV;
            flag_write_d  = 2'b00;
            reg_write_d   = 1'b0;
            mem_write_d   = 1'b0;
            mem_to_reg_d  = 1'b0;
            branch_d      = 1'b0;
            alu_src_d     = 1'b0;
            alu_control_d = 4'd0;
            rd1_d         = '0;
            rd2_d         = '0;
            ext_imm_d     = '0;
            wa3_d         = 4'd0;
            ra1_d         = 4'd0;
            ra2_d         = 4'd0;
            valid_d       = 1'b0;
        end else if (!StallE) begin
            cond_d        = CondD;
            flag_write_d  = FlagWriteD;
            reg_write_d   = RegWriteD;
            mem_write_d   = MemWriteD;
            mem_to_reg_d  = MemtoRegD;
            branch_d      = BranchD;
            alu_src_d     = ALUSrcD;
            alu_control_d = ALUControlD;
            rd1_d         = RD1D;
            rd2_d         = RD2D;
            ext_imm_d     = ExtImmD;
            wa3_d         = WA3D;
            ra1_d         = RA1D;
            ra2_d         = RA2D;
            valid_d       = 1'b1;
        end
    end

    // Bubble counter: clear wins, otherwise count flushes and saturate.
    always_comb begin
        bcnt_d = bcnt_q;
        if (BubbleClr) begin
            bcnt_d = '0;
        end else if (FlushE && (bcnt_q != BCNT_MAX)) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_q        <= COND_NV;
            flag_write_q  <= 2'b00;
            reg_write_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            branch_q      <= 1'b0;
            alu_src_q     <= 1'b0;
            alu_control_q <= 4'd0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            ext_imm_q     <= '0;
            wa3_q         <= 4'd0;
            ra1_q         <= 4'd0;
            ra2_q         <= 4'd0;
            valid_q       <= 1'b0;
            bcnt_q        <= '0;
        end else begin
            cond_q        <= cond_d;
            flag_write_q  <= flag_write_d;
            reg_write_q   <= reg_write_d;
            mem_write_q   <= mem_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            branch_q      <= branch_d;
            alu_src_q     <= alu_src_d;
            alu_control_q <= alu_control_d;
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            ext_imm_q     <= ext_imm_d;
            wa3_q         <= wa3_d;
            ra1_q         <= ra1_d;
            ra2_q         <= ra2_d;
            valid_q       <= valid_d;
            bcnt_q        <= bcnt_d;
        end
    end

    assign CondE       = cond_q;
    assign FlagWriteE  = flag_write_q;
    assign RegWriteE   = reg_write_q;
    assign MemWriteE   = mem_write_q;
    assign MemtoRegE   = mem_to_reg_q;
    assign BranchE     = branch_q;
    assign ALUSrcE     = alu_src_q;
    assign ALUControlE = alu_control_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ExtImmE     = ext_imm_q;
    assign WA3E        = wa3_q;
    assign RA1E        = ra1_q;
    assign RA2E        = ra2_q;
    assign ValidE      = valid_q;
    assign BubbleCount = bcnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a 16-bit-counter instance and a 4-bit-counter
// instance share all inputs; the small one exercises counter saturation.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallE, FlushE, BubbleClr;
    logic [3:0]  CondD, ALUControlD, WA3D, RA1D, RA2D;
    logic [1:0]  FlagWriteD;
    logic        RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD;
    logic [31:0] RD1D, RD2D, ExtImmD;

    logic [3:0]  CondE, ALUControlE, WA3E, RA1E, RA2E;
    logic [1:0]  FlagWriteE;
    logic        RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, ValidE;
    logic [31:0] RD1E, RD2E, ExtImmE;
    logic [15:0] BubbleCount;

    logic [3:0]  s_CondE, s_ALUControlE, s_WA3E, s_RA1E, s_RA2E;
    logic [1:0]  s_FlagWriteE;
    logic        s_RegWriteE, s_MemWriteE, s_MemtoRegE, s_BranchE, s_ALUSrcE, s_ValidE;
    logic [31:0] s_RD1E, s_RD2E, s_ExtImmE;
    logic [3:0]  s_BubbleCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.WIDTH(32), .BCNT_W(16)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .BubbleClr(BubbleClr),
        .CondD(CondD), .FlagWriteD(FlagWriteD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .MemtoRegD(MemtoRegD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .WA3D(WA3D), .RA1D(RA1D), .RA2D(RA2D),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemtoRegE(MemtoRegE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .WA3E(WA3E), .RA1E(RA1E), .RA2E(RA2E),
        .ValidE(ValidE), .BubbleCount(BubbleCount)
    );

    id_ex_pipe_reg #(.WIDTH(32), .BCNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .BubbleClr(BubbleClr),
        .CondD(CondD), .FlagWriteD(FlagWriteD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .MemtoRegD(MemtoRegD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .WA3D(WA3D), .RA1D(RA1D), .RA2D(RA2D),
        .CondE(s_CondE), .FlagWriteE(s_FlagWriteE), .RegWriteE(s_RegWriteE),
        .MemWriteE(s_MemWriteE), .MemtoRegE(s_MemtoRegE), .BranchE(s_BranchE),
        .ALUSrcE(s_ALUSrcE), .ALUControlE(s_ALUControlE), .RD1E(s_RD1E), .RD2E(s_RD2E),
        .ExtImmE(s_ExtImmE), .WA3E(s_WA3E), .RA1E(s_RA1E), .RA2E(s_RA2E),
        .ValidE(s_ValidE), .BubbleCount(s_BubbleCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, " CondE"},       32'(CondE), 32'hF);
        chk({tag, " FlagWriteE"},  32'(FlagWriteE), 32'h0);
        chk({tag, " RegWriteE"},   32'(RegWriteE), 32'h0);
        chk({tag, " MemWriteE"},   32'(MemWriteE), 32'h0);
        chk({tag, " BranchE"},     32'(BranchE), 32'h0);
        chk({tag, " MemtoRegE"},   32'(MemtoRegE), 32'h0);
        chk({tag, " ALUSrcE"},     32'(ALUSrcE), 32'h0);
        chk({tag, " ALUControlE"}, 32'(ALUControlE), 32'h0);
        chk({tag, " RD1E"},        RD1E, 32'h0);
        chk({tag, " RD2E"},        RD2E, 32'h0);
        chk({tag, " ExtImmE"},     ExtImmE, 32'h0);
        chk({tag, " WA3E"},        32'(WA3E), 32'h0);
        chk({tag, " RA1E"},        32'(RA1E), 32'h0);
        chk({tag, " RA2E"},        32'(RA2E), 32'h0);
        chk({tag, " ValidE"},      32'(ValidE), 32'h0);
    endtask

    task automatic drive_case2();
        CondD = 4'hE; FlagWriteD = 2'b11; RegWriteD = 1'b1; MemWriteD = 1'b1;
        MemtoRegD = 1'b1; BranchD = 1'b1; ALUSrcD = 1'b1; ALUControlD = 4'hA;
        RD1D = 32'h1234_5678; RD2D = 32'hCAFE_F00D; ExtImmD = 32'h0000_0FFF;
        WA3D = 4'd5; RA1D = 4'd7; RA2D = 4'd9;
    endtask

    task automatic chk_case2(input string tag);
        chk({tag, " CondE"},       32'(CondE), 32'hE);
        chk({tag, " FlagWriteE"},  32'(FlagWriteE), 32'h3);
        chk({tag, " RegWriteE"},   32'(RegWriteE), 32'h1);
        chk({tag, " MemWriteE"},   32'(MemWriteE), 32'h1);
        chk({tag, " MemtoRegE"},   32'(MemtoRegE), 32'h1);
        chk({tag, " BranchE"},     32'(BranchE), 32'h1);
        chk({tag, " ALUSrcE"},     32'(ALUSrcE), 32'h1);
        chk({tag, " ALUControlE"}, 32'(ALUControlE), 32'hA);
        chk({tag, " RD1E"},        RD1E, 32'h1234_5678);
        chk({tag, " RD2E"},        RD2E, 32'hCAFE_F00D);
        chk({tag, " ExtImmE"},     ExtImmE, 32'h0000_0FFF);
        chk({tag, " WA3E"},        32'(WA3E), 32'd5);
        chk({tag, " RA1E"},        32'(RA1E), 32'd7);
        chk({tag, " RA2E"},        32'(RA2E), 32'd9);
        chk({tag, " ValidE"},      32'(ValidE), 32'h1);
    endtask

    initial begin
        reset = 1'b0; StallE = 1'b0; FlushE = 1'b0; BubbleClr = 1'b0;
        CondD = 4'h0; FlagWriteD = 2'b00; RegWriteD = 1'b0; MemWriteD = 1'b0;
        MemtoRegD = 1'b0; BranchD = 1'b0; ALUSrcD = 1'b0; ALUControlD = 4'h0;
        RD1D = 32'h0; RD2D = 32'h0; ExtImmD = 32'h0; WA3D = 4'h0; RA1D = 4'h0; RA2D = 4'h0;

        // 1: reset held across clock edges keeps the bubble encoding.
        step(); step();
        chk_bubble("rst");
        chk("rst BubbleCount", 32'(BubbleCount), 32'h0);
        chk("rst small BubbleCount", 32'(s_BubbleCount), 32'h0);
        #2 reset = 1'b1;
        step();
        chk("rel load zero CondE", 32'(CondE), 32'h0);
        chk("rel load zero ValidE", 32'(ValidE), 32'h1);

        // 2: plain load, one-cycle latency.
        drive_case2();
        step();
        chk_case2("load");

        // 3: stall holds for three cycles despite new D values.
        StallE = 1'b1; CondD = 4'h0; RD1D = 32'hDEAD_BEEF;
        step(); chk_case2("stall1");
        step(); chk_case2("stall2");
        step(); chk_case2("stall3");
        chk("stall BubbleCount", 32'(BubbleCount), 32'h0);
        StallE = 1'b0;
        step();
        chk("unstall CondE", 32'(CondE), 32'h0);
        chk("unstall RD1E", RD1E, 32'hDEAD_BEEF);
        chk("unstall WA3E", 32'(WA3E), 32'd5);
        chk("unstall ValidE", 32'(ValidE), 32'h1);

        // 4: flush wins over stall and counts one bubble.
        drive_case2();
        StallE = 1'b1; FlushE = 1'b1;
        step();
        chk_bubble("flush");
        chk("flush BubbleCount", 32'(BubbleCount), 32'd1);
        chk("flush small BubbleCount", 32'(s_BubbleCount), 32'd1);
        StallE = 1'b0; FlushE = 1'b0;
        step();
        chk_case2("reload");
        chk("reload BubbleCount holds", 32'(BubbleCount), 32'd1);

        // 5: saturation on the 4-bit counter, clear beats flush.
        BubbleClr = 1'b1;
        step();
        chk("clr BubbleCount", 32'(BubbleCount), 32'd0);
        chk("clr small BubbleCount", 32'(s_BubbleCount), 32'd0);
        BubbleClr = 1'b0; FlushE = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            chk("sat big BubbleCount", 32'(BubbleCount), 32'(i));
            chk("sat small BubbleCount", 32'(s_BubbleCount), (i < 15) ? 32'(i) : 32'hF);
        end
        chk("sat small ValidE", 32'(s_ValidE), 32'h0);
        BubbleClr = 1'b1;
        step();
        chk("clr+flush BubbleCount", 32'(BubbleCount), 32'd0);
        chk("clr+flush small BubbleCount", 32'(s_BubbleCount), 32'd0);
        chk("clr+flush CondE", 32'(CondE), 32'hF);

        // 6: asynchronous reset between edges while a valid instruction is held.
        BubbleClr = 1'b0;
        step();
        chk("pre-arst BubbleCount", 32'(BubbleCount), 32'd1);
        FlushE = 1'b0;
        drive_case2();
        step();
        chk_case2("pre-arst");
        #3 reset = 1'b0;
        #1;
        chk_bubble("arst");
        chk("arst BubbleCount", 32'(BubbleCount), 32'd0);
        #2 reset = 1'b1;
        step();
        chk_case2("post-arst");
        chk("post-arst BubbleCount", 32'(BubbleCount), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish within 50000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
